// File: rtl/store_align.sv
// MEM-stage store formatter: narrows a register value into a lane-replicated,
// byte-enabled data-memory write and queues it in a 2-entry FIFO.
module store_align #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_size,
  input  logic        in_chk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [3:0]  out_be,
  output logic        out_err,
  output logic        out_ovf,
  output logic [7:0]  err_count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        err;
    logic        ovf;
  } entry_t;

  entry_t [1:0] mem_q, mem_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [7:0]   err_count_q, err_count_d;

  entry_t fmt;
  entry_t head;
  logic   push, pop;
  logic   fits_byte, fits_half;

  // A value survives sign-extending reload only if all bits above the
  // narrow field's sign bit replicate that sign bit.
  assign fits_byte = (&in_data[31:7])  | ~(|in_data[31:7]);
  assign fits_half = (&in_data[31:15]) | ~(|in_data[31:15]);

  always_comb begin
    fmt      = '0;
    fmt.addr = {in_addr[31:2], 2'b00};
    fmt.data = in_data;
    case (in_size)
      2'b00: begin
        fmt.data = {4{in_data[7:0]}};
        fmt.be   = 4'b0001 << in_addr[1:0];
        fmt.ovf  = in_chk & ~fits_byte;
      end
      2'b01: begin
        fmt.data = {2{in_data[15:0]}};
        fmt.be   = 4'b0011 << in_addr[1:0];
        fmt.err  = in_addr[0];
        fmt.ovf  = in_chk & ~fits_half;
      end
      2'b10: begin
        fmt.be  = 4'b1111;
        fmt.err = |in_addr[1:0];
      end
      default: begin
        fmt.err = 1'b1;
      end
    endcase
    if (fmt.err) begin
      fmt.be = '0;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != 2'd0);
  assign out_addr  = head.addr;
  assign out_data  = head.data;
  assign out_be    = head.be;
  assign out_err   = head.err;
  assign out_ovf   = head.ovf;
  assign err_count = err_count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    count_d     = count_q;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = fmt;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop && (head.err || head.ovf) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: directed vector table, hand-written handshake
// sequences, then random traffic checked against a queue-based model.
module tb_store_align;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        in_chk;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_err;
  logic        out_ovf;
  logic [7:0]  err_count;

  store_align #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_size   (in_size),
    .in_chk    (in_chk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_err   (out_err),
    .out_ovf   (out_ovf),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        chk;
    logic [31:0] e_data;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_err;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        err;
    logic        ovf;
  } exp_t;

  // Reference formatting from the size/offset rules using plain arithmetic.
  function automatic exp_t model_fmt(input logic [31:0] d, input logic [31:0] a,
                                     input logic [1:0] sz, input logic ck);
    exp_t e;
    int   off;
    int   s;
    int   be;
    bit   aligned;
    bit   fits;
    off = int'(a % 4);
    s   = int'($signed(d));
    e.addr = a - (a % 4);
    case (sz)
      2'd0: begin
        e.data = (d & 32'hFF) * 32'h0101_0101;
        be = 1 << off; aligned = 1; fits = (s >= -128 && s <= 127);
      end
      2'd1: begin
        e.data = (d & 32'hFFFF) * 32'h0001_0001;
        be = 3 << off; aligned = (off % 2 == 0); fits = (s >= -32768 && s <= 32767);
      end
      2'd2: begin
        e.data = d; be = 15; aligned = (off == 0); fits = 1;
      end
      default: begin
        e.data = d; be = 0; aligned = 0; fits = 1;
      end
    endcase
    e.err = !aligned;
    e.be  = e.err ? 4'd0 : 4'(be & 15);
    e.ovf = ck && !fits;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] a,
                       input logic [1:0] sz, input logic ck);
    in_valid = v;
    in_data  = d;
    in_addr  = a;
    in_size  = sz;
    in_chk   = ck;
  endtask

  vec_t tbl[11];
  exp_t q[$];
  int   exp_errcnt;

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 2'd0, 1'b0);

    tbl[0]  = '{32'h0000_00AB, 32'h0000_1003, 2'd0, 1'b0, 32'hABAB_ABAB, 32'h0000_1000, 4'b1000, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFC, 32'h0000_0002, 2'd1, 1'b1, 32'hFFFC_FFFC, 32'h0000_0000, 4'b1100, 1'b0, 1'b0};
    tbl[2]  = '{32'h0001_0000, 32'h0000_0002, 2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b1100, 1'b0, 1'b1};
    tbl[3]  = '{32'h1234_5678, 32'h0000_0006, 2'd2, 1'b0, 32'h1234_5678, 32'h0000_0004, 4'b0000, 1'b1, 1'b0};
    tbl[4]  = '{32'h0000_BEEF, 32'h0000_0001, 2'd1, 1'b0, 32'hBEEF_BEEF, 32'h0000_0000, 4'b0000, 1'b1, 1'b0};
    tbl[5]  = '{32'hCAFE_F00D, 32'h0000_0000, 2'd3, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 4'b0000, 1'b1, 1'b0};
    tbl[6]  = '{32'hFFFF_FF80, 32'h0000_0011, 2'd0, 1'b1, 32'h8080_8080, 32'h0000_0010, 4'b0010, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000_0080, 32'h0000_0022, 2'd0, 1'b1, 32'h8080_8080, 32'h0000_0020, 4'b0100, 1'b0, 1'b1};
    tbl[8]  = '{32'h8000_0000, 32'h0000_0040, 2'd2, 1'b1, 32'h8000_0000, 32'h0000_0040, 4'b1111, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_7FFF, 32'h0000_0000, 2'd1, 1'b1, 32'h7FFF_7FFF, 32'h0000_0000, 4'b0011, 1'b0, 1'b0};
    tbl[10] = '{32'h1234_5678, 32'h0000_0003, 2'd0, 1'b0, 32'h7878_7878, 32'h0000_0000, 4'b1000, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_addr",  out_addr,       32'd0);
    check("rst_out_be",    32'(out_be),    32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;

    // Directed table: one store at a time, popped the cycle it appears.
    exp_errcnt = 0;
    out_ready  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].data, tbl[i].addr, tbl[i].size, tbl[i].chk);
      @(negedge clk);
      drive(1'b0, '0, '0, 2'd0, 1'b0);
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("tbl%0d_data", i),  out_data,       tbl[i].e_data);
      check($sformatf("tbl%0d_addr", i),  out_addr,       tbl[i].e_addr);
      check($sformatf("tbl%0d_be", i),    32'(out_be),    32'(tbl[i].e_be));
      check($sformatf("tbl%0d_err", i),   32'(out_err),   32'(tbl[i].e_err));
      check($sformatf("tbl%0d_ovf", i),   32'(out_ovf),   32'(tbl[i].e_ovf));
      if (tbl[i].e_err || tbl[i].e_ovf) exp_errcnt++;
      @(negedge clk);
      check($sformatf("tbl%0d_empty", i), 32'(out_valid), 32'd0);
      check($sformatf("tbl%0d_errcnt", i), 32'(err_count), 32'(exp_errcnt));
    end

    // Backpressure: fill, hold a third request, then drain in order.
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'hAAAA_0001, 32'h0000_0100, 2'd2, 1'b0);
    @(negedge clk);
    check("bp_ready_after_a", 32'(in_ready),  32'd1);
    check("bp_valid_after_a", 32'(out_valid), 32'd1);
    drive(1'b1, 32'hBBBB_0002, 32'h0000_0104, 2'd2, 1'b0);
    @(negedge clk);
    check("bp_full",  32'(in_ready), 32'd0);
    drive(1'b1, 32'hCCCC_0003, 32'h0000_0108, 2'd2, 1'b0);
    @(negedge clk);
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_head_a",     out_data,      32'hAAAA_0001);
    check("bp_addr_a",     out_addr,      32'h0000_0100);
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_b", 32'(out_valid), 32'd1);
    check("bp_head_b",  out_data,       32'hBBBB_0002);
    check("bp_ready_b", 32'(in_ready),  32'd1);
    @(negedge clk);
    check("bp_drained",   32'(out_valid), 32'd0);
    check("bp_ready_end", 32'(in_ready),  32'd1);

    // Streaming: 8 back-to-back words, each visible one cycle after push.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("str%0d_valid", i - 1), 32'(out_valid), 32'd1);
        check($sformatf("str%0d_data", i - 1),  out_data,       32'h5000_0000 + 32'(i - 1));
        check($sformatf("str%0d_addr", i - 1),  out_addr,       32'h0000_2000 + 32'(4 * (i - 1)));
        check($sformatf("str%0d_ready", i - 1), 32'(in_ready),  32'd1);
      end
      if (i < 8) drive(1'b1, 32'h5000_0000 + 32'(i), 32'h0000_2000 + 32'(4 * i), 2'd2, 1'b0);
      else       drive(1'b0, '0, '0, 2'd0, 1'b0);
    end
    @(negedge clk);
    check("str_empty", 32'(out_valid), 32'd0);

    // Reset mid-operation with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 32'h0000_0300, 2'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h2222_2222, 32'h0000_0305, 2'd2, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    check("mr_full", 32'(in_ready), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("mr_valid",  32'(out_valid), 32'd0);
    check("mr_ready",  32'(in_ready),  32'd1);
    check("mr_errcnt", 32'(err_count), 32'd0);
    check("mr_data",   out_data,       32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0000_0077, 32'h0000_0401, 2'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    check("mr_post_valid", 32'(out_valid), 32'd1);
    check("mr_post_data",  out_data,       32'h7777_7777);
    check("mr_post_be",    32'(out_be),    32'b0010);
    out_ready = 1'b1;
    @(negedge clk);
    check("mr_post_empty", 32'(out_valid), 32'd0);

    // Random traffic vs queue model; long enough to saturate err_count.
    exp_errcnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        v, rdy, ck;
      logic [31:0] d, a;
      logic [1:0]  sz;
      int          kind;
      bit          do_push, do_pop;
      exp_t        e;
      @(negedge clk);
      check("rnd_valid",  32'(out_valid), 32'(q.size() != 0));
      check("rnd_ready",  32'(in_ready),  32'(q.size() != 2));
      check("rnd_errcnt", 32'(err_count), 32'(exp_errcnt));
      if (q.size() != 0) begin
        check("rnd_data", out_data,    q[0].data);
        check("rnd_addr", out_addr,    q[0].addr);
        check("rnd_be",   32'(out_be), 32'(q[0].be));
        check("rnd_err",  32'(out_err), 32'(q[0].err));
        check("rnd_ovf",  32'(out_ovf), 32'(q[0].ovf));
      end
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       d = $urandom;
        1:       d = 32'($signed(9'($urandom_range(0, 511))));
        2:       d = 32'($signed(17'($urandom_range(0, 131071))));
        default: d = 32'($urandom_range(0, 1) ? 32'h0000_7F80 : 32'hFFFF_8000) + 32'($urandom_range(0, 255));
      endcase
      a   = $urandom;
      sz  = 2'($urandom_range(0, 3));
      ck  = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      drive(v, d, a, sz, ck);
      out_ready = rdy;
      do_push = v && (q.size() != 2);
      do_pop  = rdy && (q.size() != 0);
      if (do_pop) begin
        e = q.pop_front();
        if ((e.err || e.ovf) && exp_errcnt < 255) exp_errcnt++;
      end
      if (do_push) q.push_back(model_fmt(d, a, sz, ck));
    end
    @(negedge clk);
    check("rnd_final_errcnt", 32'(err_count), 32'(exp_errcnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
